// File: rtl/sqrt_arbiter.sv
// rtl/sqrt_arbiter.sv - round-robin sharing of one sqrt unit between two Box-Muller channels
module sqrt_arbiter #(
    parameter int SQRT_LAT   = 1,
    parameter int FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ch0_valid,
    input  logic [30:0] ch0_e,
    input  logic [15:0] ch0_g0,
    input  logic [15:0] ch0_g1,
    input  logic [1:0]  ch0_quad,
    output logic        ch0_ready,
    input  logic        ch1_valid,
    input  logic [30:0] ch1_e,
    input  logic [15:0] ch1_g0,
    input  logic [15:0] ch1_g1,
    input  logic [1:0]  ch1_quad,
    output logic        ch1_ready,
    output logic [30:0] sq_e,
    output logic [15:0] sq_g0_,
    output logic [15:0] sq_g1_,
    output logic [1:0]  sq_quad_,
    input  logic [16:0] sq_f,
    input  logic [15:0] sq_g0,
    input  logic [15:0] sq_g1,
    input  logic [1:0]  sq_quad,
    output logic        ch0_out_valid,
    output logic [16:0] ch0_f,
    output logic [15:0] ch0_g0o,
    output logic [15:0] ch0_g1o,
    output logic [1:0]  ch0_quado,
    input  logic        ch0_out_ready,
    output logic        ch1_out_valid,
    output logic [16:0] ch1_f,
    output logic [15:0] ch1_g0o,
    output logic [15:0] ch1_g1o,
    output logic [1:0]  ch1_quado,
    input  logic        ch1_out_ready
);

    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = $clog2(FIFO_DEPTH + SQRT_LAT + 1) + 1;
    localparam int DW = 51;

    logic [1:0]          in_valid;
    logic [1:0]          out_ready;
    logic [1:0]          elig;
    logic [1:0]          grant;
    logic [1:0]          wr_en;
    logic [1:0]          rd_en;
    logic                last;
    logic [SQRT_LAT-1:0] tag_v;
    logic [SQRT_LAT-1:0] tag_ch;
    logic [CW-1:0]       count    [2];
    logic [CW-1:0]       inflight [2];
    logic [AW-1:0]       wr_ptr   [2];
    logic [AW-1:0]       rd_ptr   [2];
    logic [DW-1:0]       mem      [2][FIFO_DEPTH];
    logic [DW-1:0]       head     [2];
    logic [DW-1:0]       wr_data;

    assign in_valid  = {ch1_valid, ch0_valid};
    assign out_ready = {ch1_out_ready, ch0_out_ready};
    assign wr_data   = {sq_f, sq_g0, sq_g1, sq_quad};

    // Count tag-pipe stages owned by each channel; these results already hold a FIFO slot.
    always_comb begin
        for (int c = 0; c < 2; c++) begin
            inflight[c] = '0;
            for (int s = 0; s < SQRT_LAT; s++) begin
                if (tag_v[s] && (tag_ch[s] == 1'(c))) begin
                    inflight[c] = inflight[c] + CW'(1);
                end
            end
        end
    end

    // A channel may issue only while it has an unreserved FIFO slot.
    always_comb begin
        elig = '0;
        for (int c = 0; c < 2; c++) begin
            elig[c] = in_valid[c] && ((count[c] + inflight[c]) < CW'(FIFO_DEPTH));
        end
    end

    // Round-robin: a lone eligible channel wins, a tie goes to the one not granted last.
    always_comb begin
        grant = 2'b00;
        if (rst_n) begin
            if (elig[0] && (!elig[1] || last)) begin
                grant[0] = 1'b1;
            end else if (elig[1]) begin
                grant[1] = 1'b1;
            end
        end
    end

    assign ch0_ready = grant[0];
    assign ch1_ready = grant[1];

    // Steer the granted channel onto the sqrt unit; idle cycles present zeros.
    always_comb begin
        sq_e     = '0;
        sq_g0_   = '0;
        sq_g1_   = '0;
        sq_quad_ = '0;
        if (grant[0]) begin
            sq_e     = ch0_e;
            sq_g0_   = ch0_g0;
            sq_g1_   = ch0_g1;
            sq_quad_ = ch0_quad;
        end else if (grant[1]) begin
            sq_e     = ch1_e;
            sq_g0_   = ch1_g0;
            sq_g1_   = ch1_g1;
            sq_quad_ = ch1_quad;
        end
    end

    // Tag pipe tracks owner of every operand through the fixed sqrt latency; last tracks fairness.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            tag_v  <= '0;
            tag_ch <= '0;
            last   <= 1'b1;
        end else begin
            tag_v[0]  <= |grant;
            tag_ch[0] <= grant[1];
            for (int s = 1; s < SQRT_LAT; s++) begin
                tag_v[s]  <= tag_v[s-1];
                tag_ch[s] <= tag_ch[s-1];
            end
            if (|grant) begin
                last <= grant[1];
            end
        end
    end

    // Route the emerging result to its owner's FIFO and pop on consumer handshake.
    always_comb begin
        wr_en = '0;
        rd_en = '0;
        for (int c = 0; c < 2; c++) begin
            wr_en[c] = tag_v[SQRT_LAT-1] && (tag_ch[SQRT_LAT-1] == 1'(c));
            rd_en[c] = (count[c] != '0) && out_ready[c];
            head[c]  = mem[c][rd_ptr[c]];
        end
    end

    // Per-channel result FIFOs; storage itself needs no reset since count gates visibility.
    always_ff @(posedge clk) begin
        for (int c = 0; c < 2; c++) begin
            if (!rst_n) begin
                wr_ptr[c] <= '0;
                rd_ptr[c] <= '0;
                count[c]  <= '0;
            end else begin
                if (wr_en[c]) begin
                    mem[c][wr_ptr[c]] <= wr_data;
                    wr_ptr[c]         <= wr_ptr[c] + AW'(1);
                end
                if (rd_en[c]) begin
                    rd_ptr[c] <= rd_ptr[c] + AW'(1);
                end
                case ({wr_en[c], rd_en[c]})
                    2'b10:   count[c] <= count[c] + CW'(1);
                    2'b01:   count[c] <= count[c] - CW'(1);
                    default: count[c] <= count[c];
                endcase
            end
        end
    end

    // The credit rule must make a write into a full FIFO impossible.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            for (int c = 0; c < 2; c++) begin
                assert (!(wr_en[c] && (count[c] == CW'(FIFO_DEPTH))));
            end
        end
    end

    assign ch0_out_valid = (count[0] != '0);
    assign ch1_out_valid = (count[1] != '0);
    assign {ch0_f, ch0_g0o, ch0_g1o, ch0_quado} = ch0_out_valid ? head[0] : '0;
    assign {ch1_f, ch1_g0o, ch1_g1o, ch1_quado} = ch1_out_valid ? head[1] : '0;

endmodule

// File: tb/tb_sqrt_arbiter.sv
// tb/tb_sqrt_arbiter.sv - scoreboard bench for sqrt_arbiter (instance 0: LAT1/D4, instance 1: LAT4/D2)
module tb_sqrt_arbiter;

    logic        clk;
    logic        rst_n     [2];
    logic        valid     [2][2];
    logic [30:0] e         [2][2];
    logic [15:0] g0        [2][2];
    logic [15:0] g1        [2][2];
    logic [1:0]  quad      [2][2];
    logic        ready     [2][2];
    logic        out_valid [2][2];
    logic [16:0] f         [2][2];
    logic [15:0] g0o       [2][2];
    logic [15:0] g1o       [2][2];
    logic [1:0]  quado     [2][2];
    logic        out_ready [2][2];
    logic [30:0] sq_e      [2];
    logic [15:0] sq_g0_    [2];
    logic [15:0] sq_g1_    [2];
    logic [1:0]  sq_quad_  [2];
    logic [16:0] sq_f      [2];
    logic [15:0] sq_g0     [2];
    logic [15:0] sq_g1     [2];
    logic [1:0]  sq_quad   [2];
    logic [50:0] stub      [2][4];

    logic [50:0] sbq [4][$];
    bit          xfer [2][2];
    int          pops [2][2];
    int          n_checks;
    int          n_pass;
    bit          rand_on;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    sqrt_arbiter #(.SQRT_LAT(1), .FIFO_DEPTH(4)) u_dut_a (
        .clk(clk), .rst_n(rst_n[0]),
        .ch0_valid(valid[0][0]), .ch0_e(e[0][0]), .ch0_g0(g0[0][0]), .ch0_g1(g1[0][0]),
        .ch0_quad(quad[0][0]), .ch0_ready(ready[0][0]),
        .ch1_valid(valid[0][1]), .ch1_e(e[0][1]), .ch1_g0(g0[0][1]), .ch1_g1(g1[0][1]),
        .ch1_quad(quad[0][1]), .ch1_ready(ready[0][1]),
        .sq_e(sq_e[0]), .sq_g0_(sq_g0_[0]), .sq_g1_(sq_g1_[0]), .sq_quad_(sq_quad_[0]),
        .sq_f(sq_f[0]), .sq_g0(sq_g0[0]), .sq_g1(sq_g1[0]), .sq_quad(sq_quad[0]),
        .ch0_out_valid(out_valid[0][0]), .ch0_f(f[0][0]), .ch0_g0o(g0o[0][0]),
        .ch0_g1o(g1o[0][0]), .ch0_quado(quado[0][0]), .ch0_out_ready(out_ready[0][0]),
        .ch1_out_valid(out_valid[0][1]), .ch1_f(f[0][1]), .ch1_g0o(g0o[0][1]),
        .ch1_g1o(g1o[0][1]), .ch1_quado(quado[0][1]), .ch1_out_ready(out_ready[0][1])
    );

    sqrt_arbiter #(.SQRT_LAT(4), .FIFO_DEPTH(2)) u_dut_b (
        .clk(clk), .rst_n(rst_n[1]),
        .ch0_valid(valid[1][0]), .ch0_e(e[1][0]), .ch0_g0(g0[1][0]), .ch0_g1(g1[1][0]),
        .ch0_quad(quad[1][0]), .ch0_ready(ready[1][0]),
        .ch1_valid(valid[1][1]), .ch1_e(e[1][1]), .ch1_g0(g0[1][1]), .ch1_g1(g1[1][1]),
        .ch1_quad(quad[1][1]), .ch1_ready(ready[1][1]),
        .sq_e(sq_e[1]), .sq_g0_(sq_g0_[1]), .sq_g1_(sq_g1_[1]), .sq_quad_(sq_quad_[1]),
        .sq_f(sq_f[1]), .sq_g0(sq_g0[1]), .sq_g1(sq_g1[1]), .sq_quad(sq_quad[1]),
        .ch0_out_valid(out_valid[1][0]), .ch0_f(f[1][0]), .ch0_g0o(g0o[1][0]),
        .ch0_g1o(g1o[1][0]), .ch0_quado(quado[1][0]), .ch0_out_ready(out_ready[1][0]),
        .ch1_out_valid(out_valid[1][1]), .ch1_f(f[1][1]), .ch1_g0o(g0o[1][1]),
        .ch1_g1o(g1o[1][1]), .ch1_quado(quado[1][1]), .ch1_out_ready(out_ready[1][1])
    );

    // Stub sqrt units: f = e[16:0] ^ 17'h15555, side data passed through, fixed latency.
    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            stub[i][0] <= {sq_e[i][16:0] ^ 17'h15555, sq_g0_[i], sq_g1_[i], sq_quad_[i]};
            for (int s = 1; s < 4; s++) stub[i][s] <= stub[i][s-1];
        end
    end
    assign {sq_f[0], sq_g0[0], sq_g1[0], sq_quad[0]} = stub[0][0];
    assign {sq_f[1], sq_g0[1], sq_g1[1], sq_quad[1]} = stub[1][3];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    function automatic logic [50:0] model(input logic [30:0] ev, input logic [15:0] a,
                                          input logic [15:0] b, input logic [1:0] q);
        return {ev[16:0] ^ 17'h15555, a, b, q};
    endfunction

    // Scoreboard: push at accepted handshake, pop and compare at consumer handshake.
    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            for (int c = 0; c < 2; c++) begin
                if (!rst_n[i]) begin
                    sbq[i*2+c].delete();
                    xfer[i][c] <= 1'b0;
                end else begin
                    if (out_valid[i][c]) begin
                        check($sformatf("sb_nonempty_%0d%0d", i, c), 64'(sbq[i*2+c].size() != 0), 64'd1);
                        if (out_ready[i][c] && (sbq[i*2+c].size() != 0)) begin
                            logic [50:0] exp_v;
                            exp_v = sbq[i*2+c].pop_front();
                            check($sformatf("sb_data_%0d%0d", i, c),
                                  64'({f[i][c], g0o[i][c], g1o[i][c], quado[i][c]}), 64'(exp_v));
                            pops[i][c] <= pops[i][c] + 1;
                        end
                    end else begin
                        check($sformatf("idle_zero_%0d%0d", i, c),
                              64'({f[i][c], g0o[i][c], g1o[i][c], quado[i][c]}), 64'd0);
                    end
                    xfer[i][c] <= valid[i][c] && ready[i][c];
                    if (valid[i][c] && ready[i][c]) begin
                        sbq[i*2+c].push_back(model(e[i][c], g0[i][c], g1[i][c], quad[i][c]));
                    end
                    if (i == 1) begin
                        check($sformatf("outstanding_1%0d", c), 64'(sbq[2+c].size() <= 2), 64'd1);
                    end
                end
            end
        end
    end

    // One clock step; new operand payload after each transfer, random traffic on instance 1.
    task automatic tick();
        @(posedge clk);
        #1;
        for (int i = 0; i < 2; i++) begin
            for (int c = 0; c < 2; c++) begin
                if (xfer[i][c]) begin
                    e[i][c]    = 31'($urandom);
                    g0[i][c]   = 16'($urandom);
                    g1[i][c]   = 16'($urandom);
                    quad[i][c] = 2'($urandom);
                end
            end
        end
        if (rand_on) begin
            for (int c = 0; c < 2; c++) begin
                if (!valid[1][c] || xfer[1][c]) valid[1][c] = 1'($urandom_range(0, 1));
                out_ready[1][c] = 1'($urandom_range(0, 1));
            end
        end
    endtask

    task automatic reset_inst(input int i);
        rst_n[i] = 1'b0;
        tick();
        rst_n[i] = 1'b1;
    endtask

    initial begin
        bit [4:0]    ovb;
        int          n;
        int          base0;
        int          base1;
        logic [50:0] exp2;

        n_checks = 0;
        n_pass   = 0;
        rand_on  = 1'b0;
        for (int i = 0; i < 2; i++) begin
            rst_n[i] = 1'b0;
            for (int c = 0; c < 2; c++) begin
                valid[i][c]     = 1'b0;
                e[i][c]         = 31'($urandom);
                g0[i][c]        = 16'($urandom);
                g1[i][c]        = 16'($urandom);
                quad[i][c]      = 2'($urandom);
                out_ready[i][c] = 1'b1;
            end
        end
        valid[0][0] = 1'b1;
        valid[0][1] = 1'b1;
        repeat (3) tick();

        // Reset state
        @(negedge clk);
        check("rst_ready0", 64'(ready[0][0]), 64'd0);
        check("rst_ready1", 64'(ready[0][1]), 64'd0);
        check("rst_sq_e", 64'({sq_e[0], sq_g0_[0], sq_g1_[0], sq_quad_[0]}), 64'd0);
        check("rst_ov_a0", 64'(out_valid[0][0]), 64'd0);
        check("rst_ov_b1", 64'(out_valid[1][1]), 64'd0);
        check("rst_f_a0", 64'({f[0][0], g0o[0][0], g1o[0][0], quado[0][0]}), 64'd0);
        tick();
        valid[0][0] = 1'b0;
        valid[0][1] = 1'b0;
        rst_n[0] = 1'b1;
        rst_n[1] = 1'b1;

        // Single operand on ch0
        valid[0][0] = 1'b1;
        e[0][0]     = 31'h0000_00FF;
        g0[0][0]    = 16'h1234;
        g1[0][0]    = 16'hABCD;
        quad[0][0]  = 2'b10;
        @(negedge clk);
        check("single_ready0", 64'(ready[0][0]), 64'd1);
        check("single_ready1", 64'(ready[0][1]), 64'd0);
        tick();
        valid[0][0] = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            ovb[k] = out_valid[0][0];
            check("single_ch1_idle", 64'(out_valid[0][1]), 64'd0);
            if (k == 1) begin
                check("single_f", 64'(f[0][0]), 64'h155AA);
                check("single_g0", 64'(g0o[0][0]), 64'h1234);
                check("single_g1", 64'(g1o[0][0]), 64'hABCD);
                check("single_quad", 64'(quado[0][0]), 64'd2);
            end
            tick();
        end
        check("single_ov_window", 64'(ovb), 64'b00010);

        // Continuous tie
        reset_inst(0);
        base0 = pops[0][0];
        base1 = pops[0][1];
        valid[0][0] = 1'b1;
        valid[0][1] = 1'b1;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            check("tie_ready0", 64'(ready[0][0]), 64'(k % 2 == 0));
            check("tie_ready1", 64'(ready[0][1]), 64'(k % 2 == 1));
            tick();
        end
        valid[0][0] = 1'b0;
        valid[0][1] = 1'b0;
        repeat (6) tick();
        #1;
        check("tie_results0", 64'(pops[0][0] - base0), 64'd10);
        check("tie_results1", 64'(pops[0][1] - base1), 64'd10);

        // ch0 back-pressure
        reset_inst(0);
        out_ready[0][0] = 1'b0;
        valid[0][0] = 1'b1;
        valid[0][1] = 1'b1;
        for (int k = 0; k < 14; k++) begin
            @(negedge clk);
            check("bp_ready0", 64'(ready[0][0]), 64'((k < 8) && (k % 2 == 0)));
            check("bp_ready1", 64'(ready[0][1]), 64'(!((k < 8) && (k % 2 == 0))));
            tick();
        end
        out_ready[0][0] = 1'b1;
        base0 = pops[0][0];
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            check("bp_resume0", 64'(ready[0][0]), 64'(k % 2 == 1));
            check("bp_resume1", 64'(ready[0][1]), 64'(k % 2 == 0));
            tick();
        end
        #1;
        check("bp_drained_ge4", 64'(pops[0][0] - base0 >= 4), 64'd1);
        valid[0][0] = 1'b0;
        valid[0][1] = 1'b0;
        repeat (8) tick();

        // FIFO steady state: two held, one push and one pop on the same edge
        reset_inst(0);
        out_ready[0][0] = 1'b0;
        valid[0][0] = 1'b1;
        tick();
        tick();
        valid[0][0] = 1'b0;
        repeat (3) tick();
        @(negedge clk);
        #1;
        check("st_prefill", 64'(sbq[0].size()), 64'd2);
        check("st_ov", 64'(out_valid[0][0]), 64'd1);
        check("st_head1", 64'({f[0][0], g0o[0][0], g1o[0][0], quado[0][0]}), 64'(sbq[0][0]));
        exp2 = sbq[0][1];
        tick();
        valid[0][0] = 1'b1;
        @(negedge clk);
        check("st_ready3", 64'(ready[0][0]), 64'd1);
        tick();
        valid[0][0] = 1'b0;
        out_ready[0][0] = 1'b1;
        tick();
        out_ready[0][0] = 1'b0;
        @(negedge clk);
        #1;
        check("st_ov_after", 64'(out_valid[0][0]), 64'd1);
        check("st_head2", 64'({f[0][0], g0o[0][0], g1o[0][0], quado[0][0]}), 64'(exp2));
        check("st_count2", 64'(sbq[0].size()), 64'd2);
        tick();
        out_ready[0][0] = 1'b1;
        n = 0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            n += int'(out_valid[0][0]);
            tick();
        end
        check("st_drain_count", 64'(n), 64'd2);

        // Reset mid-operation on the deep-latency instance
        reset_inst(1);
        valid[1][1] = 1'b1;
        e[1][1]     = 31'h10;
        @(negedge clk);
        check("rm_ready1", 64'(ready[1][1]), 64'd1);
        tick();
        valid[1][1] = 1'b0;
        valid[1][0] = 1'b1;
        @(negedge clk);
        check("rm_ready0", 64'(ready[1][0]), 64'd1);
        tick();
        valid[1][0] = 1'b0;
        rst_n[1] = 1'b0;
        tick();
        rst_n[1] = 1'b1;
        n = 0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            n += int'(out_valid[1][0]) + int'(out_valid[1][1]);
            tick();
        end
        check("rm_no_output", 64'(n), 64'd0);
        valid[1][0] = 1'b1;
        valid[1][1] = 1'b1;
        @(negedge clk);
        check("rm_tie_ch0", 64'(ready[1][0]), 64'd1);
        check("rm_tie_ch1", 64'(ready[1][1]), 64'd0);

        // Deep latency random traffic
        base0 = pops[1][0];
        base1 = pops[1][1];
        rand_on = 1'b1;
        repeat (2000) tick();
        rand_on = 1'b0;
        valid[1][0] = 1'b0;
        valid[1][1] = 1'b0;
        out_ready[1][0] = 1'b1;
        out_ready[1][1] = 1'b1;
        repeat (12) tick();
        @(negedge clk);
        #1;
        check("rand_traffic0", 64'(pops[1][0] - base0 > 100), 64'd1);
        check("rand_traffic1", 64'(pops[1][1] - base1 > 100), 64'd1);
        for (int q = 0; q < 4; q++) check($sformatf("end_empty_%0d", q), 64'(sbq[q].size()), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
